// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the core's MEM stage, with a byte-serial
// loader that assembles little-endian words and commits them when the core is idle.
module data_mem_responder #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [31:0]          ram_addr,
    input  logic [31:0]          ram_wdata,
    input  logic                 ram_we,
    output logic [31:0]          ram_rdata,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_byte,
    output logic                 ld_ready,
    output logic [ADDR_BITS-1:0] ld_ptr,
    output logic                 ld_wrap
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } ld_state_t;

    ld_state_t              state_reg;
    ld_state_t              state_next;
    logic [1:0]             byte_idx_reg;
    logic [ADDR_BITS-1:0]   ptr_reg;
    logic [31:0]            shadow_reg;
    logic                   wrap_reg;
    logic                   ready_comb;

    logic [31:0]            mem_reg [DEPTH];

    logic                   in_range;
    logic [ADDR_BITS-1:0]   core_idx;
    logic                   core_wr;
    logic                   commit;
    logic                   accept;

    assign in_range = (ram_addr[31:ADDR_BITS] == '0);
    assign core_idx = ram_addr[ADDR_BITS-1:0];
    assign core_wr  = ram_we && in_range;

    // The core owns the write port whenever ram_we is high, even for an
    // out-of-range store, so the loader only commits on fully idle cycles.
    assign commit   = (state_reg == COMMIT) && !ld_start && !ram_we;
    assign accept   = ready_comb && ld_valid && !ld_start;

    // Combinational read: a store this cycle becomes visible next cycle.
    assign ram_rdata = in_range ? mem_reg[core_idx] : '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (!clr) begin
                    mem_reg[gi] <= '0;
                end else if (core_wr && (core_idx == ADDR_BITS'(gi))) begin
                    mem_reg[gi] <= ram_wdata;
                end else if (commit && (ptr_reg == ADDR_BITS'(gi))) begin
                    mem_reg[gi] <= shadow_reg;
                end
            end
        end
    endgenerate

    // Loader FSM: state register
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Loader FSM: next state
    always_comb begin
        state_next = state_reg;
        if (ld_start) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                COLLECT: if (ld_valid && (byte_idx_reg == 2'd3)) state_next = COMMIT;
                COMMIT:  if (!ram_we) state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    // Loader FSM: outputs
    always_comb begin
        ready_comb = 1'b0;
        case (state_reg)
            COLLECT: ready_comb = 1'b1;
            COMMIT:  ready_comb = 1'b0;
            default: ready_comb = 1'b0;
        endcase
    end

    // Loader datapath; ld_start leaves the shadow word untouched.
    always_ff @(posedge clk) begin
        if (!clr) begin
            byte_idx_reg <= '0;
            ptr_reg      <= '0;
            shadow_reg   <= '0;
            wrap_reg     <= 1'b0;
        end else begin
            wrap_reg <= commit && (ptr_reg == '1);
            if (ld_start) begin
                byte_idx_reg <= '0;
                ptr_reg      <= '0;
            end else if (accept) begin
                shadow_reg[8*byte_idx_reg +: 8] <= ld_byte;
                byte_idx_reg                    <= byte_idx_reg + 2'd1;
            end else if (commit) begin
                ptr_reg      <= ptr_reg + ADDR_BITS'(1);
                byte_idx_reg <= '0;
            end
        end
    end

    assign ld_ready = ready_comb;
    assign ld_ptr   = ptr_reg;
    assign ld_wrap  = wrap_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: reset, core load/store, loader
// word assembly, core-priority stall, pointer wrap and mid-word restart.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic [3:0]  ld_ptr;
    logic        ld_wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_cnt = 0;

    data_mem_responder #(.ADDR_BITS(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_byte   (ld_byte),
        .ld_ready  (ld_ready),
        .ld_ptr    (ld_ptr),
        .ld_wrap   (ld_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ld_wrap) wrap_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ram_we   = 1'b0;
        ram_addr = addr;
        #1;
        check(tag, ram_rdata, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        ld_valid = 1'b1;
        ld_byte  = b;
        guard    = 0;
        while (!ld_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!ld_ready) check("ld_ready_timeout", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    initial begin
        clr = 1'b0; ram_addr = '0; ram_wdata = '0; ram_we = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
        step(); step();
        clr = 1'b1;

        // Scribble some words, then reset and expect a clean memory.
        ram_we = 1'b1;
        ram_addr = 32'd1; ram_wdata = 32'hCAFE0001; step();
        ram_addr = 32'd9; ram_wdata = 32'hCAFE0009; step();
        ram_we = 1'b0;
        read_check("pre_reset_mem9", 32'd9, 32'hCAFE0009);
        clr = 1'b0; step(); clr = 1'b1;
        for (int i = 0; i < 16; i++) read_check($sformatf("reset_mem%0d", i), 32'(i), 32'h0);
        check("reset_ld_ready", 32'(ld_ready), 32'd1);
        check("reset_ld_ptr",   32'(ld_ptr),   32'd0);
        check("reset_ld_wrap",  32'(ld_wrap),  32'd0);

        // Core store: old data this cycle, new data next cycle.
        ram_we = 1'b1; ram_addr = 32'd5; ram_wdata = 32'hDEADBEEF; #1;
        check("store_same_cycle", ram_rdata, 32'h0);
        step();
        read_check("store_next_cycle", 32'd5, 32'hDEADBEEF);

        // Out-of-range store dropped; out-of-range read is zero.
        ram_we = 1'b1; ram_addr = 32'h10; ram_wdata = 32'h1234; step();
        read_check("oor_read", 32'h10, 32'h0);
        read_check("oor_mem0", 32'd0, 32'h0);
        read_check("oor_high_read", 32'h8000_0005, 32'h0);

        // Loader word, back-to-back bytes.
        send_word(32'h12345678);
        check("ld_commit_ready", 32'(ld_ready), 32'd0);
        step();
        check("ld_after_ready", 32'(ld_ready), 32'd1);
        check("ld_after_ptr",   32'(ld_ptr),   32'd1);
        read_check("ld_mem0", 32'd0, 32'h12345678);

        // Core holds the write port for three cycles while the loader waits.
        send_word(32'h04030201);
        ram_we = 1'b1; ram_addr = 32'd3; ram_wdata = 32'hA5A5A5A5;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stall%0d_ready", c), 32'(ld_ready), 32'd0);
            check($sformatf("stall%0d_ptr", c), 32'(ld_ptr), 32'd1);
            step();
        end
        ram_we = 1'b0; #1;
        check("stall_end_ready", 32'(ld_ready), 32'd0);
        step();
        check("coll_ready", 32'(ld_ready), 32'd1);
        check("coll_ptr",   32'(ld_ptr),   32'd2);
        read_check("coll_mem3", 32'd3, 32'hA5A5A5A5);
        read_check("coll_mem1", 32'd1, 32'h04030201);
        read_check("coll_mem0", 32'd0, 32'h12345678);

        // Wrap: restart pointer, load 16 words.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        check("start_ptr", 32'(ld_ptr), 32'd0);
        wrap_cnt = 0;
        for (int w = 0; w < 16; w++) begin
            send_word(32'(w));
            step();
            check($sformatf("wrap_pulse_w%0d", w), 32'(ld_wrap), (w == 15) ? 32'd1 : 32'd0);
        end
        check("wrap_ptr", 32'(ld_ptr), 32'd0);
        step();
        check("wrap_cleared", 32'(ld_wrap), 32'd0);
        check("wrap_count", 32'(wrap_cnt), 32'd1);
        for (int i = 0; i < 16; i++) read_check($sformatf("wrap_mem%0d", i), 32'(i), 32'(i));

        // Restart mid-word after advancing the pointer.
        send_word(32'h00000055);
        step();
        check("rs_ptr1", 32'(ld_ptr), 32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        ld_start = 1'b1; step(); ld_start = 1'b0;
        check("rs_ptr0",  32'(ld_ptr),   32'd0);
        check("rs_ready", 32'(ld_ready), 32'd1);
        send_word(32'h44332211);
        step();
        read_check("rs_mem0", 32'd0, 32'h44332211);
        read_check("rs_mem1", 32'd1, 32'h00000001);
        check("rs_ptr_end", 32'(ld_ptr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
